// File: rtl/fetch_if_id_pkg.sv
// Shared constants and types for the WISC-SP20 fetch stage.
package fetch_if_id_pkg;

  localparam logic [15:0] RESET_PC_DEF = 16'h0000;
  localparam logic [15:0] NOP_INS_DEF  = 16'h0800;
  localparam logic [4:0]  HALT_OP_DEF  = 5'b00000;
  localparam int          OPC_MSB      = 15;
  localparam int          OPC_LSB      = 11;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_op(input logic [15:0] ins, input logic [4:0] op);
    return ins[OPC_MSB:OPC_LSB] == op;
  endfunction

endpackage

// File: rtl/fetch_if_id_pc_reg.sv
// Program counter: async-reset register with load / increment-by-2 / hold.
module fetch_if_id_pc_reg
  import fetch_if_id_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        inc_i,
  output logic [15:0] pc_o
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i)     pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + 16'd2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_if_id.sv
// Fetch stage and IF/ID register; absorbs imem wait states, obeys stall/flush, freezes on HALT.
// state     | meaning
// ST_RUN    | fetching normally
// ST_HALTED | HALT captured; PC frozen until flush
module fetch_if_id
  import fetch_if_id_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEF,
  parameter logic [15:0] NOP_INS  = NOP_INS_DEF,
  parameter logic [4:0]  HALT_OP  = HALT_OP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_decode,
  input  logic        flush_fetch,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_rdata,
  input  logic        imem_done,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  output logic [15:0] ins_IF_ID,
  output logic [15:0] pc_plus2_IF_ID,
  output logic        valid_IF_ID,
  output logic        fetch_halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  ins_q, ins_d;
  logic [15:0]  pc2_q, pc2_d;
  logic         valid_q, valid_d;
  logic [15:0]  pc_w;
  logic         pc_load, pc_inc;

  fetch_if_id_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .load_val_i (branch_target),
    .inc_i      (pc_inc),
    .pc_o       (pc_w)
  );

  always_comb begin
    state_d = state_q;
    ins_d   = ins_q;
    pc2_d   = pc2_q;
    valid_d = valid_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    if (flush_fetch) begin
      pc_load = 1'b1;
      ins_d   = NOP_INS;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (stall_decode) begin
      // hold everything; returned data is dropped and re-requested
    end else if (state_q == ST_HALTED || !imem_done) begin
      ins_d   = NOP_INS;
      valid_d = 1'b0;
    end else begin
      ins_d   = imem_rdata;
      pc2_d   = pc_w + 16'd2;
      valid_d = 1'b1;
      if (is_op(imem_rdata, HALT_OP)) state_d = ST_HALTED;
      else                            pc_inc  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      ins_q   <= NOP_INS;
      pc2_q   <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ins_q   <= ins_d;
      pc2_q   <= pc2_d;
      valid_q <= valid_d;
    end
  end

  assign fetch_halted   = (state_q == ST_HALTED);
  assign imem_req       = ~fetch_halted & ~rst;
  assign imem_addr      = pc_w;
  assign ins_IF_ID      = ins_q;
  assign pc_plus2_IF_ID = pc2_q;
  assign valid_IF_ID    = valid_q;

endmodule

// File: tb/tb_fetch_if_id.sv
// Directed bench for fetch_if_id with a cycle-level behavioural model and literal pins.
module tb_fetch_if_id;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_decode, flush_fetch;
  logic [15:0] branch_target;
  logic [15:0] imem_rdata;
  logic        imem_done;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] ins_IF_ID, pc_plus2_IF_ID;
  logic        valid_IF_ID, fetch_halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] halt_addr = 16'hFFFF;

  // memory image: every word is 4001 + word index, except the planted HALT
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == halt_addr) return 16'h0000;
    return 16'h4001 + {1'b0, a[15:1]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_if_id dut (
    .clk            (clk),
    .rst            (rst),
    .stall_decode   (stall_decode),
    .flush_fetch    (flush_fetch),
    .branch_target  (branch_target),
    .imem_rdata     (imem_rdata),
    .imem_done      (imem_done),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .ins_IF_ID      (ins_IF_ID),
    .pc_plus2_IF_ID (pc_plus2_IF_ID),
    .valid_IF_ID    (valid_IF_ID),
    .fetch_halted   (fetch_halted)
  );

  always #5 clk = ~clk;

  // behavioural model
  logic [15:0] m_pc, m_ins, m_pc2;
  logic        m_valid, m_halted;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 16'h0000; m_ins = 16'h0800; m_pc2 = 16'h0000;
      m_valid = 1'b0;  m_halted = 1'b0;
    end else if (flush_fetch) begin
      m_pc = branch_target; m_ins = 16'h0800; m_valid = 1'b0; m_halted = 1'b0;
    end else if (stall_decode) begin
      m_pc = m_pc;
    end else if (m_halted || !imem_done) begin
      m_ins = 16'h0800; m_valid = 1'b0;
    end else begin
      m_ins   = mem_word(m_pc);
      m_pc2   = m_pc + 16'd2;
      m_valid = 1'b1;
      if (m_ins[15:11] == 5'b00000) m_halted = 1'b1;
      else                          m_pc = m_pc + 16'd2;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_imem_addr", imem_addr, m_pc);
    chk("m_imem_req", {15'd0, imem_req}, {15'd0, ~m_halted & ~rst});
    chk("m_ins", ins_IF_ID, m_ins);
    chk("m_pc2", pc_plus2_IF_ID, m_pc2);
    chk("m_valid", {15'd0, valid_IF_ID}, {15'd0, m_valid});
    chk("m_halted", {15'd0, fetch_halted}, {15'd0, m_halted});
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic redirect(input logic [15:0] t);
    flush_fetch = 1'b1; branch_target = t;
    step();
    flush_fetch = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall_decode = 1'b0; flush_fetch = 1'b0;
    branch_target = 16'h0000; imem_done = 1'b0;
    #1;
    chk("rst_ins", ins_IF_ID, 16'h0800);
    chk("rst_valid", {15'd0, valid_IF_ID}, 16'd0);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0; imem_done = 1'b1;

    // sequential fetch
    step();
    chk("t1_ins0", ins_IF_ID, 16'h4001);
    chk("t1_pc2_0", pc_plus2_IF_ID, 16'h0002);
    step();
    chk("t1_ins1", ins_IF_ID, 16'h4002);
    chk("t1_pc2_1", pc_plus2_IF_ID, 16'h0004);
    chk("t1_valid", {15'd0, valid_IF_ID}, 16'd1);
    step();

    // stall at PC 0006
    stall_decode = 1'b1;
    step(); step();
    chk("t2_addr", imem_addr, 16'h0006);
    chk("t2_ins", ins_IF_ID, 16'h4003);

    // flush beats stall
    flush_fetch = 1'b1; branch_target = 16'h0040;
    step();
    flush_fetch = 1'b0; stall_decode = 1'b0;
    chk("t3_addr", imem_addr, 16'h0040);
    chk("t3_ins", ins_IF_ID, 16'h0800);
    chk("t3_valid", {15'd0, valid_IF_ID}, 16'd0);
    step();
    chk("t3_fetch", ins_IF_ID, 16'h4021);

    // wait states at PC 0010
    redirect(16'h0010);
    imem_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_bubble", ins_IF_ID, 16'h0800);
      chk("t4_addr", imem_addr, 16'h0010);
    end
    imem_done = 1'b1;
    step();
    chk("t4_ins", ins_IF_ID, 16'h4009);
    chk("t4_pc2", pc_plus2_IF_ID, 16'h0012);

    // HALT at 0020, then release by flush
    halt_addr = 16'h0020;
    redirect(16'h0020);
    step();
    chk("t5_ins", ins_IF_ID, 16'h0000);
    chk("t5_valid", {15'd0, valid_IF_ID}, 16'd1);
    chk("t5_halted", {15'd0, fetch_halted}, 16'd1);
    chk("t5_req", {15'd0, imem_req}, 16'd0);
    step();
    chk("t5_nop", ins_IF_ID, 16'h0800);
    chk("t5_pc_frozen", imem_addr, 16'h0020);
    redirect(16'h0030);
    chk("t5_unhalt", {15'd0, fetch_halted}, 16'd0);
    step();
    chk("t5_resume", ins_IF_ID, 16'h4019);
    chk("t5_resume_pc2", pc_plus2_IF_ID, 16'h0032);

    // PC wrap, then reset mid-wait
    redirect(16'hFFFE);
    step();
    chk("t6_ins", ins_IF_ID, 16'hC000);
    chk("t6_pc2", pc_plus2_IF_ID, 16'h0000);
    chk("t6_addr", imem_addr, 16'h0000);
    step(); step();
    imem_done = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("t6_rst_ins", ins_IF_ID, 16'h0800);
    chk("t6_rst_pc2", pc_plus2_IF_ID, 16'h0000);
    chk("t6_rst_valid", {15'd0, valid_IF_ID}, 16'd0);
    chk("t6_rst_addr", imem_addr, 16'h0000);
    chk("t6_rst_req", {15'd0, imem_req}, 16'd0);
    step();
    rst = 1'b0; imem_done = 1'b1;
    step();
    chk("t6_refetch", ins_IF_ID, 16'h4001);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
